muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the HI/LO multiply/divide resource of the MIPS CPU.
- Accepts MULT/MULTU/DIV/DIVU from the decode/control stage and runs a radix-2 iterative shift-add multiply or restoring divide.
- Owns the HI/LO registers and services MTHI/MTLO.
- Asserts busy so the top-level controller stalls any MFHI/MFLO or further mul/div until done.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_val  input  WIDTH  operand A (multiplicand / dividend)
rt_val  input  WIDTH  operand B (multiplier / divisor)
mthi  input  1  write wdata to HI
mtlo  input  1  write wdata to LO
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  high in PREP, CALC, FIX
done  output  1  one-cycle pulse; HI/LO hold the new result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: one clock, asynchronous active-low (rst_n low → immediate clear); released synchronously to clk.
  - Reset values: state IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
  - Reset mid-operation aborts the operation; no partial result is written.
- FSM states: IDLE, PREP, CALC, FIX, DONE.
  - IDLE: start=1 → latch op, rs_val, rt_val → PREP. Otherwise stay.
  - PREP (1 cycle):
    - Signed ops: take absolute values; record neg_q = A[msb]^B[msb] and neg_r = A[msb].
    - Unsigned ops: neg_q = neg_r = 0.
    - Clear the 2*WIDTH accumulator and the counter.
  - CALC (exactly WIDTH cycles, counter 0..WIDTH-1, then → FIX):
    - Multiply: if multiplier LSB is 1, add the multiplicand to the upper half; shift right 1.
    - Divide: shift remainder:quotient left 1; trial subtract the divisor; if non-negative, keep it and set quotient LSB.
  - FIX (1 cycle):
    - Multiply: negate the 2*WIDTH product if neg_q.
    - Divide: negate the quotient if neg_q; negate the remainder if neg_r.
    - On the edge leaving FIX: multiply writes {hi,lo} = product; divide writes lo = quotient, hi = remainder. Next state DONE.
  - DONE (1 cycle): done=1, busy=0 → IDLE.
- Latency: start sampled at edge E0; done high in the cycle after E(WIDTH+2). That is 35 cycles for WIDTH=32.
- Divide by zero (B=0): no exception. Result is lo = all-ones, hi = A, for both DIV and DIVU; the FIX sign correction is skipped.
- Signed overflow (0x80000000 / -1): lo = 0x80000000, hi = 0. No flag.
- start while busy or in DONE: ignored; no queueing.
- mthi/mtlo:
  - Honoured only in IDLE; written on the clock edge.
  - Both may be asserted together; each writes its own register from wdata.
  - Ignored in every other state.
- start and mthi/mtlo in the same IDLE cycle: start wins; the mt writes are dropped.
- hi/lo are stable throughout an operation and change only on the FIX→DONE edge or an IDLE mt write.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state encodings
  - default WIDTH
- One sub-module, muldiv_iter_step: combinational single-iteration step. Inputs are accumulator, operand and mode; output is the next accumulator. The sequencer keeps all registers and the FSM.

Test Plan:
- MULTU FFFFFFFF × FFFFFFFF → hi=FFFFFFFE, lo=00000001; done exactly 35 cycles after start; busy high for 34 cycles.
- MULT -3 (FFFFFFFD) × 5 → hi=FFFFFFFF, lo=FFFFFFF1; DIV -7/2 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU 100/7 → lo=0000000E, hi=00000002; DIVU 1234/0 → lo=FFFFFFFF, hi=000004D2; DIV 80000000/FFFFFFFF → lo=80000000, hi=0.
- Second start plus mthi pulsed mid-CALC with wdata=AAAAAAAA → ignored; result equals the first operation only; hi≠AAAAAAAA.
- rst_n low at counter=10 → immediate hi=lo=0, busy=0, done never pulses; a new MULTU 2×3 after release → lo=6, hi=0.
- In IDLE: mthi and mtlo with wdata=12345678 → both equal 12345678 next cycle; start+mtlo in the same cycle → mtlo dropped, operation runs.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 5;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_CALC,
      S_FIX,
      S_DONE
   } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Control-side handshake for the HI/LO multiply/divide resource.
interface muldiv_if
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_val, rt_val,
      output mthi, mtlo, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val,
      input  mthi, mtlo, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide
// on the {upper, lower} accumulator using unsigned magnitudes.
module muldiv_iter_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   opnd,
   input  logic               is_div,
   output logic [2*WIDTH-1:0] acc_nxt
);
   logic [WIDTH:0] sum;
   logic [WIDTH:0] shl;
   logic [WIDTH:0] diff;

   always_comb begin
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
      shl     = acc[2*WIDTH-1:WIDTH-1];
      diff    = shl - {1'b0, opnd};
      acc_nxt = '0;
      if (is_div) begin
         // msb of diff set means the trial subtract went negative
         if (!diff[WIDTH])
            acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_nxt = {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         if (acc[0])
            acc_nxt = {sum, acc[WIDTH-1:1]};
         else
            acc_nxt = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
      end
   end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic     clk,
   input logic     rst_n,
   muldiv_if.slave bus
);
   state_e             state, state_nxt;
   op_e                op_q;
   logic [WIDTH-1:0]   a_q, b_q, opnd;
   logic [2*WIDTH-1:0] acc, acc_step, prod;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [CNT_W-1:0]   cnt;
   logic               neg_q, neg_r;
   logic               busy, done;
   logic               is_div, is_sgn, a_neg, b_neg, div0;
   logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;

   always_comb begin
      is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
      is_sgn = (op_q == OP_DIV) || (op_q == OP_MULT);
      a_neg  = is_sgn & a_q[WIDTH-1];
      b_neg  = is_sgn & b_q[WIDTH-1];
      a_mag  = a_neg ? -a_q : a_q;
      b_mag  = b_neg ? -b_q : b_q;
      div0   = (b_q == '0);
      prod   = neg_q ? -acc : acc;
      quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
      .acc     (acc),
      .opnd    (opnd),
      .is_div  (is_div),
      .acc_nxt (acc_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         S_IDLE: if (bus.start) state_nxt = S_PREP;
         S_PREP: begin
            busy      = 1'b1;
            state_nxt = S_CALC;
         end
         S_CALC: begin
            busy = 1'b1;
            if (cnt == '1) state_nxt = S_FIX;
         end
         S_FIX: begin
            busy      = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= OP_MULT;
         a_q   <= '0;
         b_q   <= '0;
         opnd  <= '0;
         acc   <= '0;
         cnt   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  op_q <= op_e'(bus.op);
                  a_q  <= bus.rs_val;
                  b_q  <= bus.rt_val;
               end else begin
                  if (bus.mthi) hi_q <= bus.wdata;
                  if (bus.mtlo) lo_q <= bus.wdata;
               end
            end
            S_PREP: begin
               neg_q <= a_neg ^ b_neg;
               neg_r <= a_neg;
               opnd  <= is_div ? b_mag : a_mag;
               acc   <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
               cnt   <= '0;
            end
            S_CALC: begin
               acc <= acc_step;
               cnt <= cnt + CNT_W'(1);
            end
            S_FIX: begin
               // divide by zero returns raw dividend, no sign fixup
               if (is_div && div0) begin
                  lo_q <= '1;
                  hi_q <= a_q;
               end else if (is_div) begin
                  lo_q <= quo;
                  hi_q <= rem;
               end else begin
                  {hi_q, lo_q} <= prod;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer against a timeline model.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bit   cmp_en = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   muldiv_if #(.WIDTH(W)) bus ();

   muldiv_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [65:0] act,
                      input logic [65:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [63:0] model(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint p;
      int     sq, sr;
      logic [63:0] r;
      r = '0;
      case (op)
         OP_MULT: begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p;
         end
         OP_MULTU: r = {32'h0, a} * {32'h0, b};
         OP_DIV: begin
            if (b == 0) r = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               r = {32'h0, 32'h8000_0000};
            else begin
               sq = $signed(a) / $signed(b);
               sr = $signed(a) % $signed(b);
               r  = {sr, sq};
            end
         end
         default: begin
            if (b == 0) r = {a, 32'hFFFF_FFFF};
            else r = {a % b, a / b};
         end
      endcase
      return r;
   endfunction

   int          m_cnt = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [63:0] m_res = '0;

   // busy for W+2 cycles after start, then one done cycle
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= 0;
         m_hi  <= '0;
         m_lo  <= '0;
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 2) {m_hi, m_lo} <= m_res;
      end else if (bus.start) begin
         m_res <= model(bus.op, bus.rs_val, bus.rt_val);
         m_cnt <= W + 3;
      end else begin
         if (bus.mthi) m_hi <= bus.wdata;
         if (bus.mtlo) m_lo <= bus.wdata;
      end
   end

   always @(negedge clk) begin
      if (cmp_en)
         chk("cycle", {bus.busy, bus.done, bus.hi, bus.lo},
             {(m_cnt >= 2), (m_cnt == 1), m_hi, m_lo});
   end

   task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh,
                         input logic [31:0] el, input string nm,
                         input bit disturb, input bit mt);
      int n, nb;
      bus.start  = 1'b1;
      bus.op     = op;
      bus.rs_val = a;
      bus.rt_val = b;
      if (mt) begin
         bus.mtlo  = 1'b1;
         bus.wdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.mtlo  = 1'b0;
      n  = 1;
      nb = 0;
      while (!bus.done && n < 100) begin
         if (bus.busy) nb++;
         if (disturb && n == 10) begin
            bus.start  = 1'b1;
            bus.op     = OP_MULTU;
            bus.rs_val = 32'd5;
            bus.rt_val = 32'd5;
            bus.mthi   = 1'b1;
            bus.wdata  = 32'hAAAA_AAAA;
         end else begin
            bus.start = 1'b0;
            bus.mthi  = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      chk({nm, "_lat"}, 66'(n), 66'(35));
      chk({nm, "_busy"}, 66'(nb), 66'(34));
      chk({nm, "_hi"}, 66'(bus.hi), 66'(eh));
      chk({nm, "_lo"}, 66'(bus.lo), 66'(el));
      if (disturb)
         chk({nm, "_hi_not_mt"}, 66'(bus.hi == 32'hAAAA_AAAA), 66'(0));
      @(negedge clk);
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.op     = 2'b00;
      bus.rs_val = '0;
      bus.rt_val = '0;
      bus.mthi   = 1'b0;
      bus.mtlo   = 1'b0;
      bus.wdata  = '0;

      chk("model_mult", 66'(model(OP_MULT, 32'hFFFF_FFFD, 32'd5)),
          66'(64'hFFFF_FFFF_FFFF_FFF1));
      chk("model_divu", 66'(model(OP_DIVU, 32'd100, 32'd7)),
          66'(64'h0000_0002_0000_000E));
      chk("model_div", 66'(model(OP_DIV, 32'hFFFF_FFF9, 32'd2)),
          66'(64'hFFFF_FFFF_FFFF_FFFD));

      #12;
      chk("reset", {bus.busy, bus.done, bus.hi, bus.lo}, '0);
      @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);

      bus.mthi  = 1'b1;
      bus.mtlo  = 1'b1;
      bus.wdata = 32'h1234_5678;
      @(negedge clk);
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      chk("mt_hi", 66'(bus.hi), 66'(32'h1234_5678));
      chk("mt_lo", 66'(bus.lo), 66'(32'h1234_5678));

      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0, 0);
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5,
             32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg", 0, 0);
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 0, 0);
      run_op(OP_DIVU, 32'd100, 32'd7,
             32'h0000_0002, 32'h0000_000E, "divu_dist", 1, 0);
      run_op(OP_DIVU, 32'd1234, 32'd0,
             32'h0000_04D2, 32'hFFFF_FFFF, "divu_zero", 0, 0);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h0000_0000, 32'h8000_0000, "div_ovf", 0, 0);
      run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9,
             32'h0000_0002, 32'hFFFF_FFF2, "div_mt", 0, 1);

      bus.start  = 1'b1;
      bus.op     = OP_MULTU;
      bus.rs_val = 32'd7;
      bus.rt_val = 32'd9;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (11) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort", {bus.busy, bus.done, bus.hi, bus.lo}, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(OP_MULTU, 32'd2, 32'd3,
             32'h0000_0000, 32'h0000_0006, "multu_post", 0, 0);

      repeat (2) @(negedge clk);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
